ptw_req_queue: RTL
==================

// Module: ptw_req_queue
// PURPOSE
//  Consumer stage behind the 2-input address-request arbiter. Buffers arbitrated
//  translation requests (addr + source id), issues them one at a time to the
//  page-table walker, and routes each walk response back to the requester
//  selected by the stored source id. Lets the arbiter's requesters stall only on a full buffer.
// PARAMETERS
//  ADDR_W   27  request address width (VPN)
//  DATA_W   44  walk response payload width (PTE/PPN)
//  DEPTH    4   request buffer entries; power of two, >=2
//  ID_W     2   source-id width, matches arbiter chosen index
// PORTS
//  clock             in   1       single clock, all state on rising edge
//  reset             in   1       asynchronous, active-low; clears all state
//  in_valid          in   1       arbiter output valid
//  in_ready          out  1       buffer can accept (= !full)
//  in_bits_valid     in   1       payload live; 0 = nullified request
//  in_bits_addr      in   ADDR_W  request address
//  in_chosen         in   ID_W    source index from arbiter
//  flush             in   1       discard queued and in-flight work
//  walk_req_valid    out  1       request to walker
//  walk_req_ready    in   1       walker accepts
//  walk_req_addr     out  ADDR_W  head-entry address
//  walk_resp_valid   in   1       walker response strobe (no backpressure)
//  walk_resp_data    in   DATA_W  response payload
//  walk_resp_err     in   1       walk fault
//  resp_valid        out  2       one-hot pulse, bit i = requester i
//  resp_data         out  DATA_W  payload, valid with resp_valid
//  resp_err          out  1       fault, valid with resp_valid
//  count             out  $clog2(DEPTH)+1  occupied entries incl. in-flight
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; FSM IDLE; count=0; FIFO empty.
//  Enqueue on in_valid&&in_ready && !flush. Entries with in_bits_valid=0 or
//   in_chosen>=2 are accepted (handshake completes) but never written.
//  in_ready = !full only; no same-cycle bypass when full, even if dequeuing.
//  FSM states IDLE, REQ, WAIT, RESP:
//   IDLE: head present -> REQ next cycle (enqueue-to-walk_req_valid = 1 cycle).
//   REQ:  walk_req_valid=1, addr=head addr, held stable until walk_req_ready; -> WAIT.
//   WAIT: on walk_resp_valid capture data/err -> RESP.
//   RESP: resp_valid[head id]=1 for exactly one cycle, pop head -> IDLE.
//  Head stays in FIFO until RESP; count includes it. Strictly one walk in flight.
//  walk_resp_valid outside WAIT is ignored.
//  flush (1 cycle, any state): clears all non-head entries; in IDLE/REQ also drops
//   head and goes IDLE (walk_req_valid drops next cycle); in WAIT sets drop flag,
//   walk completes, response is swallowed (no resp_valid), head popped, -> IDLE.
//   Flush and enqueue same cycle: flush wins, new request not stored.
//  Pointers wrap modulo DEPTH; count saturates never (full blocks input).
//  Reset mid-walk: immediate return to IDLE; a later walk_resp_valid is ignored.
// STRUCTURE
//  Package ptw_req_pkg: ADDR_W/DATA_W/ID_W constants, state_e enum,
//   req_entry_t struct {addr, id}.
//  Sub-module ptw_req_fifo: DEPTH-entry sync FIFO of req_entry_t with
//   push/pop/clear_tail/clear_all, full/empty/count.
//  Top: FSM, response capture register, one-hot demux of resp_valid.
// TESTING
//  1. Single: in_chosen=1 addr=0x1234567, ready=1, resp 3 cycles later data=0xABC
//     -> walk_req_valid cycle+1, resp_valid=2'b10 resp_data=0xABC one cycle.
//  2. Fill: 5 back-to-back reqs, walker stalled -> in_ready=0 after 4th, count=4,
//     5th held by arbiter; drains in order with ids preserved.
//  3. Nullified: in_bits_valid=0 addr=0x7 -> handshake accepted, no walk_req, count=0.
//  4. Flush in WAIT with 2 queued -> walk resp arrives, resp_valid stays 0,
//     count=0, FSM IDLE; next new request walks normally.
//  5. walk_req_ready low 10 cycles -> walk_req_addr/valid stable throughout.
//  6. Async reset asserted in WAIT -> outputs reset immediately; later
//     walk_resp_valid produces no resp_valid.

Source files
------------

// File: rtl/ptw_req_pkg.sv
// Shared types for the page-table-walk request queue: widths, FSM states, buffer entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ptw_req_pkg;

  localparam int ADDR_W  = 27;  // request address (VPN)
  localparam int DATA_W  = 44;  // walk response payload (PTE/PPN)
  localparam int ID_W    = 2;   // arbiter chosen-index width
  localparam int NUM_REQ = 2;   // requesters that can receive a response

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } req_entry_t;

endpackage

// File: rtl/ptw_req_fifo.sv
// Synchronous request buffer; head stays resident until popped, tail can be flushed alone.
// Latency: push visible at head on the next cycle; head_dat is combinational from storage.
// Backpressure: caller must not push when full; clear_all/clear_tail override push/pop.
// Ports: push/push_dat write at tail, pop retires head, clear_tail keeps only the head,
//        clear_all empties; head_dat/full/empty/count describe the current contents.
module ptw_req_fifo
  import ptw_req_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  req_entry_t       push_dat,
  input  logic             pop,
  input  logic             clear_tail,
  input  logic             clear_all,
  output req_entry_t       head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  req_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear_all || (clear_tail && pop)) begin
      // Dropping the tail while retiring the head leaves nothing behind.
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear_tail) begin
      if (cnt != '0) begin
        wr_ptr <= rd_ptr + PTR_W'(1);
        cnt    <= CNT_W'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/ptw_req_queue.sv
// Buffers arbitrated translation requests, walks them one at a time, routes responses by source id.
// Latency: enqueue to walk_req_valid 1 cycle; walk response to resp_valid 1 cycle.
// Backpressure: in_ready = !full only; walker request is valid/ready, walker response has none.
// Ports: in_* from the arbiter, flush discards work, walk_req_*/walk_resp_* to/from the walker,
//        resp_* one-hot response to requesters, count = buffered entries including in-flight.
module ptw_req_queue
  import ptw_req_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bits_valid,
  input  logic [ADDR_W-1:0] in_bits_addr,
  input  logic [ID_W-1:0]   in_chosen,
  input  logic              flush,
  output logic              walk_req_valid,
  input  logic              walk_req_ready,
  output logic [ADDR_W-1:0] walk_req_addr,
  input  logic              walk_resp_valid,
  input  logic [DATA_W-1:0] walk_resp_data,
  input  logic              walk_resp_err,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [CNT_W-1:0]  count
);

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              push, pop, clear_tail, clear_all, full, empty;
  req_entry_t        head;
  req_entry_t        new_entry;

  assign in_ready = !full;

  // Nullified requests and out-of-range ids complete the handshake but are not stored.
  assign push = in_valid && in_ready && !flush && in_bits_valid
             && (int'(in_chosen) < NUM_REQ);

  assign new_entry.addr = in_bits_addr;
  assign new_entry.id   = in_chosen;

  ptw_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_dat   (new_entry),
    .pop        (pop),
    .clear_tail (clear_tail),
    .clear_all  (clear_all),
    .head_dat   (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (state_q == WAIT && walk_resp_valid) begin
        data_q <= walk_resp_data;
        err_q  <= walk_resp_err;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    pop            = 1'b0;
    clear_tail     = 1'b0;
    clear_all      = 1'b0;
    walk_req_valid = 1'b0;
    walk_req_addr  = '0;
    resp_valid     = '0;
    case (state_q)
      IDLE: begin
        // Looking at push as well as !empty saves a cycle on an idle queue.
        if (flush)               clear_all = 1'b1;
        else if (push || !empty) state_d   = REQ;
      end
      REQ: begin
        walk_req_valid = 1'b1;
        walk_req_addr  = head.addr;
        if (flush) begin
          clear_all = 1'b1;
          state_d   = IDLE;
        end else if (walk_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The walker cannot be cancelled, so a flush here only marks the result for discard.
        if (flush) begin
          clear_tail = 1'b1;
          drop_d     = 1'b1;
        end
        if (walk_resp_valid) state_d = RESP;
      end
      RESP: begin
        pop        = 1'b1;
        clear_tail = flush;
        resp_valid[head.id[0]] = !drop_q;
        drop_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = data_q;
  assign resp_err  = err_q;

endmodule
